// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: turns bit-reversed FFT128 output into natural bin order.
// A ping-pong pair of N-entry complex banks lets frames stream back to back
// without stalls; the writer fills one bank while the reader drains the other.
// Optional build macro FFT_REORDER_INDEX_EN adds the out_idx port, which
// carries the natural bin index of the current dout.
module fft_bitrev_reorder #(
    parameter int N      = 128,
    parameter int LOG2N  = 7,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] din_r,
    input  logic signed [DATA_W-1:0] din_i,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] dout_r,
    output logic signed [DATA_W-1:0] dout_i,
    output logic                     frame_start
`ifdef FFT_REORDER_INDEX_EN
    ,
    output logic [LOG2N-1:0]         out_idx
`endif
);

    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    typedef enum logic {S_IDLE, S_READ} state_t;

    state_t              r_state, w_state_nxt;
    logic [LOG2N-1:0]    r_wcnt;
    logic [LOG2N-1:0]    r_rcnt, w_rcnt_nxt;
    logic                r_wbank;
    logic                r_rbank, w_rbank_nxt;
    logic [1:0]          r_full;
    logic [1:0]          w_set, w_clr;
    logic                w_wlast;
    logic                w_rd_en;

    // Both banks share one array; the top address bit selects the bank.
    logic [2*DATA_W-1:0] r_mem [0:2*N-1];
    logic [2*DATA_W-1:0] r_rdata_p0;
    logic                r_vld_p0;
    logic                r_first_p0;
`ifdef FFT_REORDER_INDEX_EN
    logic [LOG2N-1:0]    r_idx_p0;
`endif

    function automatic logic [LOG2N-1:0] f_bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] v;
        v = '0;
        for (int k = 0; k < LOG2N; k++) begin
            v[k] = a[LOG2N-1-k];
        end
        return v;
    endfunction

    assign w_wlast = in_valid && (r_wcnt == LAST);
    assign w_set   = w_wlast ? (2'b01 << r_wbank) : 2'b00;

    // Write pointer, write bank and full flags; a set and a clear on
    // different banks in the same edge both land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt  <= '0;
            r_wbank <= 1'b0;
            r_full  <= 2'b00;
        end else begin
            if (in_valid) begin
                r_wcnt <= w_wlast ? '0 : r_wcnt + 1'b1;
                if (w_wlast) begin
                    r_wbank <= ~r_wbank;
                end
            end
            r_full <= (r_full & ~w_clr) | w_set;
        end
    end

    // Buffer write: arrival j lands at its natural bin address bitrev(j).
    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_mem[{r_wbank, f_bitrev(r_wcnt)}] <= {din_r, din_i};
        end
    end

    // Read FSM next state. Banks are drained in the order they were filled,
    // so r_rbank always names the oldest full bank. IDLE issues the bin-0
    // read itself so the first bin costs no extra cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_rcnt_nxt  = r_rcnt;
        w_rbank_nxt = r_rbank;
        w_rd_en     = 1'b0;
        w_clr       = 2'b00;
        case (r_state)
            S_IDLE:  w_rd_en = r_full[r_rbank];
            S_READ:  w_rd_en = 1'b1;
            default: w_rd_en = 1'b0;
        endcase
        if (w_rd_en) begin
            if (r_rcnt == LAST) begin
                w_clr       = 2'b01 << r_rbank;
                w_rbank_nxt = ~r_rbank;
                w_rcnt_nxt  = '0;
                w_state_nxt = r_full[~r_rbank] ? S_READ : S_IDLE;
            end else begin
                w_rcnt_nxt  = r_rcnt + 1'b1;
                w_state_nxt = S_READ;
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_rcnt  <= '0;
            r_rbank <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rcnt  <= w_rcnt_nxt;
            r_rbank <= w_rbank_nxt;
        end
    end

    // Stage p0: synchronous RAM read data.
    always_ff @(posedge clk) begin
        if (w_rd_en) begin
            r_rdata_p0 <= r_mem[{r_rbank, r_rcnt}];
`ifdef FFT_REORDER_INDEX_EN
            r_idx_p0   <= r_rcnt;
`endif
        end
    end

    // Stage p0: valid and first-bin marker travelling with the read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p0   <= 1'b0;
            r_first_p0 <= 1'b0;
        end else begin
            r_vld_p0   <= w_rd_en;
            r_first_p0 <= w_rd_en && (r_rcnt == '0);
        end
    end

    // Stage p1: output register; data holds while no bin is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
            dout_r      <= '0;
            dout_i      <= '0;
`ifdef FFT_REORDER_INDEX_EN
            out_idx     <= '0;
`endif
        end else begin
            out_valid   <= r_vld_p0;
            frame_start <= r_vld_p0 && r_first_p0;
            if (r_vld_p0) begin
                dout_r  <= r_rdata_p0[2*DATA_W-1:DATA_W];
                dout_i  <= r_rdata_p0[DATA_W-1:0];
`ifdef FFT_REORDER_INDEX_EN
                out_idx <= r_idx_p0;
`endif
            end
        end
    end

endmodule
